// File: rtl/dht11_ctrl.sv
// DHT11 single-wire sensor reader: start pulse, response handshake, 40-bit frame decode.
// Optional checksum verification is enabled by defining DHT11_CHECKSUM_EN.
module dht11_ctrl #(
    parameter int CLKS_PER_US   = 50,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] humid_int,
    output logic [7:0] humid_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec
);

    localparam int TMAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int TW   = $clog2(TMAX + 2);
    localparam int PW   = $clog2(CLKS_PER_US + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_LOW = 3'd1,
        WAIT_RESP = 3'd2,
        RESP_LOW  = 3'd3,
        RESP_HIGH = 3'd4,
        BIT_LOW   = 3'd5,
        BIT_HIGH  = 3'd6,
        CHECK     = 3'd7
    } state_t;

    state_t          state_r, state_s;
    logic            sync1_r, sync2_r, prev_r;
    logic            fall_s, rise_s, tick_s, timeout_s, bit_s;
    logic [PW-1:0]   presc_r;
    logic [TW-1:0]   timer_r;
    logic [5:0]      bitcnt_r;
    logic [39:0]     shreg_r;
    logic            dht_oe_s, busy_s, done_s, err_s, load_s, shift_s;
    logic [1:0]      err_code_s;

    // Mod-256 sum of the four data bytes of a frame.
    function automatic logic [7:0] sum8(input logic [39:0] f);
        return f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

    assign fall_s    = prev_r & ~sync2_r;
    assign rise_s    = ~prev_r & sync2_r;
    assign tick_s    = (presc_r == PW'(CLKS_PER_US - 1));
    assign timeout_s = (timer_r >= TW'(TIMEOUT_US));
    assign bit_s     = (timer_r > TW'(BIT_THRESH_US));

    // Line synchronizer and edge-detect history; idles high like the pull-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= dht_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Free-running microsecond prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Phase timer: restarts on every state change, counts microseconds.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if (state_s != state_r) begin
            timer_r <= '0;
        end else if (tick_s && (state_r != IDLE)) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:      if (start) state_s = START_LOW; else state_s = IDLE;
            START_LOW: if (timer_r >= TW'(START_LOW_US)) state_s = WAIT_RESP; else state_s = START_LOW;
            WAIT_RESP: if (fall_s) state_s = RESP_LOW; else if (timeout_s) state_s = IDLE; else state_s = WAIT_RESP;
            RESP_LOW:  if (rise_s) state_s = RESP_HIGH; else if (timeout_s) state_s = IDLE; else state_s = RESP_LOW;
            RESP_HIGH: if (fall_s) state_s = BIT_LOW; else if (timeout_s) state_s = IDLE; else state_s = RESP_HIGH;
            BIT_LOW:   if (rise_s) state_s = BIT_HIGH; else if (timeout_s) state_s = IDLE; else state_s = BIT_LOW;
            BIT_HIGH: begin
                if (fall_s) begin
                    if (bitcnt_r == 6'd39) state_s = CHECK; else state_s = BIT_LOW;
                end else if (timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = BIT_HIGH;
                end
            end
            CHECK:     state_s = IDLE;
            default:   state_s = IDLE;
        endcase
    end

    // Output decode; values are registered below so outputs align with the state.
    always_comb begin
        dht_oe_s   = (state_s == START_LOW);
        busy_s     = (state_s != IDLE);
        done_s     = 1'b0;
        err_s      = 1'b0;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        err_code_s = err_code;
        case (state_r)
            IDLE: begin
                if (start) err_code_s = 2'b00; else err_code_s = err_code;
            end
            WAIT_RESP, RESP_LOW, RESP_HIGH: begin
                if (state_s == IDLE) begin
                    err_s      = 1'b1;
                    err_code_s = 2'b01;
                end else begin
                    err_s      = 1'b0;
                end
            end
            BIT_LOW: begin
                if (state_s == IDLE) begin
                    err_s      = 1'b1;
                    err_code_s = 2'b10;
                end else begin
                    err_s      = 1'b0;
                end
            end
            BIT_HIGH: begin
                if (fall_s) begin
                    shift_s    = 1'b1;
                end else if (timeout_s) begin
                    err_s      = 1'b1;
                    err_code_s = 2'b10;
                end else begin
                    shift_s    = 1'b0;
                end
            end
            CHECK: begin
`ifdef DHT11_CHECKSUM_EN
                if (sum8(shreg_r) == shreg_r[7:0]) begin
                    load_s     = 1'b1;
                    done_s     = 1'b1;
                end else begin
                    err_s      = 1'b1;
                    err_code_s = 2'b11;
                end
`else
                load_s = 1'b1;
                done_s = 1'b1;
`endif
            end
            default: begin
                err_s = 1'b0;
            end
        endcase
    end

    // Bit counter and 40-bit frame shift register, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt_r <= 6'd0;
            shreg_r  <= 40'd0;
        end else begin
            if (state_r == RESP_HIGH) bitcnt_r <= 6'd0;
            else if (shift_s)         bitcnt_r <= bitcnt_r + 6'd1;
            else                      bitcnt_r <= bitcnt_r;
            if (shift_s) shreg_r <= {shreg_r[38:0], bit_s};
            else         shreg_r <= shreg_r;
        end
    end

    // Registered outputs; data bytes change only on a passing frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            dht_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            humid_int <= 8'd0;
            humid_dec <= 8'd0;
            temp_int  <= 8'd0;
            temp_dec  <= 8'd0;
        end else begin
            dht_oe   <= dht_oe_s;
            busy     <= busy_s;
            done     <= done_s;
            err      <= err_s;
            err_code <= err_code_s;
            if (load_s) begin
                humid_int <= shreg_r[39:32];
                humid_dec <= shreg_r[31:24];
                temp_int  <= shreg_r[23:16];
                temp_dec  <= shreg_r[15:8];
            end else begin
                humid_int <= humid_int;
                humid_dec <= humid_dec;
                temp_int  <= temp_int;
                temp_dec  <= temp_dec;
            end
        end
    end

endmodule

// File: tb/tb_dht11_ctrl.sv
// Bench for dht11_ctrl: sensor line model, vector table and a result scoreboard.
// Timing is scaled down (2 clk/us, 100 us start pulse) to keep runs short.
module tb_dht11_ctrl;
    localparam int CPU = 2;
    localparam int SL  = 100;
    localparam int TO  = 200;
    localparam int TH  = 40;
    localparam int BLO = 30;
    localparam int H0  = 27;
    localparam int H1  = 70;

    logic       clk = 1'b0;
    logic       rst, start, dht_in;
    logic       dht_oe, busy, done, err;
    logic [1:0] err_code;
    logic [7:0] humid_int, humid_dec, temp_int, temp_dec;

    dht11_ctrl #(.CLKS_PER_US(CPU), .START_LOW_US(SL), .TIMEOUT_US(TO), .BIT_THRESH_US(TH)) dut (
        .clk(clk), .rst(rst), .start(start), .dht_in(dht_in), .dht_oe(dht_oe),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .humid_int(humid_int), .humid_dec(humid_dec), .temp_int(temp_int), .temp_dec(temp_dec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] frame;
        int          stop;
        bit          noresp;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        err;
        logic [1:0]  code;
        logic [31:0] data;
        int          kind;
    } exp_t;

    exp_t q[$];
    vec_t vt[7];
    int   total = 0, bad = 0;
    int   res_cnt = 0, fall_cyc = 0, rel_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic us(input int n);
        repeat (n * CPU) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Sensor: checks the host start pulse, then answers and sends bits up to 'stop'.
    task automatic sensor(input logic [39:0] f, input int stop, input bit noresp);
        int n;
        n = 0;
        while (dht_oe !== 1'b1 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        n = 0;
        while (dht_oe === 1'b1 && n < SL * CPU * 2) begin
            @(posedge clk); #1; n++;
        end
        chk_rng("oe_low_cycles", n, SL * CPU - 2, SL * CPU + 2);
        rel_cyc = cyc;
        if (noresp) return;
        us(20);
        dht_in = 1'b0; us(80);
        dht_in = 1'b1; us(80);
        for (int i = 0; i < 40; i++) begin
            dht_in = 1'b0; us(BLO);
            dht_in = 1'b1;
            if (i == stop) return;
            us(f[39 - i] ? H1 : H0);
        end
        dht_in = 1'b0;
        fall_cyc = cyc;
        us(BLO);
        dht_in = 1'b1;
    endtask

    task automatic wait_res(input int target);
        int n;
        n = 0;
        while (res_cnt < target && n < 5000) begin
            @(posedge clk); n++;
        end
        chk_rng("result_count", res_cnt, target, target);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   tgt;
        e.err  = v.exp_err;
        e.code = v.exp_code;
        e.data = v.exp_data;
        e.kind = v.noresp ? 1 : ((v.stop < 40) ? 2 : 0);
        q.push_back(e);
        tgt = res_cnt + 1;
        pulse_start();
        chk("code_clear", {30'd0, err_code}, 32'd0);
        chk("busy_accept", {31'd0, busy}, 32'd1);
        sensor(v.frame, v.stop, v.noresp);
        wait_res(tgt);
    endtask

    // Scoreboard: every done/err pulse pops and checks one expected result.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done === 1'b1 || err === 1'b1) begin
            res_cnt++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result done=%b err=%b code=%b", done, err, err_code);
            end else begin
                e = q.pop_front();
                chk("done", {31'd0, done}, {31'd0, ~e.err});
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("err_code", {30'd0, err_code}, {30'd0, e.code});
                chk("data", {humid_int, humid_dec, temp_int, temp_dec}, e.data);
                chk("busy_at_end", {31'd0, busy}, 32'd0);
                if (e.kind == 0) chk("done_latency", cyc - fall_cyc, 32'd4);
                else if (e.kind == 1) chk_rng("resp_timeout", cyc - rel_cyc, TO * CPU - 2, TO * CPU + 4);
                else chk("busy_drop", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        int tgt;
        vt[0] = '{40'h3700190555, 40, 1'b0, 1'b0, 2'b00, 32'h37001905};
`ifdef DHT11_CHECKSUM_EN
        vt[1] = '{40'h3700190500, 40, 1'b0, 1'b1, 2'b11, 32'h37001905};
        vt[2] = '{40'h1234567800, 40, 1'b0, 1'b1, 2'b11, 32'h37001905};
        vt[3] = '{40'h20011A023D, 40, 1'b0, 1'b0, 2'b00, 32'h20011A02};
`else
        vt[1] = '{40'h3700190500, 40, 1'b0, 1'b0, 2'b00, 32'h37001905};
        vt[2] = '{40'h1234567800, 40, 1'b0, 1'b0, 2'b00, 32'h12345678};
        vt[3] = '{40'h20011A023D, 40, 1'b0, 1'b0, 2'b00, 32'h20011A02};
`endif
        vt[4] = '{40'h0000000000, 40, 1'b1, 1'b1, 2'b01, 32'h20011A02};
        vt[5] = '{40'hA5A5A5A5A5, 12, 1'b0, 1'b1, 2'b10, 32'h20011A02};
        vt[6] = '{40'h4107160967, 40, 1'b0, 1'b0, 2'b00, 32'h41071609};

        rst = 1'b1; start = 1'b0; dht_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {dht_oe, busy, done, err, err_code, 26'd0}, 32'd0);
        chk("reset_data", {humid_int, humid_dec, temp_int, temp_dec}, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Reset during the high phase of bit 20, then a clean frame.
        pulse_start();
        sensor(40'hFFFFFFFFFF, 19, 1'b0);
        us(10);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("midframe_rst_ctrl", {dht_oe, busy, done, err, err_code, 26'd0}, 32'd0);
        chk("midframe_rst_data", {humid_int, humid_dec, temp_int, temp_dec}, 32'd0);
        rst = 1'b0;
        run_vec('{40'h3700190555, 40, 1'b0, 1'b0, 2'b00, 32'h37001905});

        // Starts issued while busy must be ignored.
        q.push_back('{1'b0, 2'b00, 32'hAA550FF0, 0});
        tgt = res_cnt + 1;
        pulse_start();
        fork
            sensor(40'hAA550FF0FE, 40, 1'b0);
            begin
                us(50); pulse_start();
                us(1500); pulse_start();
            end
        join
        wait_res(tgt);
        repeat (40) @(negedge clk);
        chk("no_requeue_busy", {31'd0, busy}, 32'd0);
        chk("no_requeue_oe", {31'd0, dht_oe}, 32'd0);
        chk("no_extra_result", res_cnt, tgt);

        // Reset wins over a simultaneous start.
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        repeat (3) @(negedge clk);
        chk("rst_over_start", {30'd0, busy, dht_oe}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
